iter_div_generic: RTL and testbench

Iterative radix-2 non-restoring integer divider: the inverse of the pipelined Booth multiplier in the arithmetic datapath. It accepts a dividend and divisor of `WIDTH` bits under the same `sign_mode` convention as the multiplier, and returns quotient and remainder. The ready/valid handshake lets it sit beside the multiplier in the shared execute stage. The multiplier bench feeds its products back through this block to close the loop.

---
 rtl/iter_div_generic_pkg.sv | 20 ++
 rtl/iter_div_generic_abs_neg.sv | 17 +
 rtl/iter_div_generic.sv | 155 +++++++++++++++
 tb/tb_iter_div_generic.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_generic_pkg.sv
// Shared definitions for the iterative divider.
//   state_t     : FSM state encodings (IDLE, PREP, ITER, FIX, DONE)
//   SM_A_SIGNED : sign_mode bit that marks the dividend (operand A) as signed
//   SM_B_SIGNED : sign_mode bit that marks the divisor (operand B) as signed
// The sign_mode bit positions match the Booth multiplier, so both blocks can
// be driven from the same execute-stage decode.
package iter_div_generic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int SM_A_SIGNED = 1;
  localparam int SM_B_SIGNED = 0;

endpackage

// File: rtl/iter_div_generic_abs_neg.sv
// arith_abs_neg: conditional two's-complement negate.
//   value  in  WIDTH : operand
//   neg    in  1     : 1 = return -value (mod 2^WIDTH), 0 = pass value through
//   result out WIDTH : value or its negation
// Fed with an operand and its sign bit this yields the magnitude; fed with
// a magnitude and the wanted result sign it restores the sign.
module arith_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/iter_div_generic.sv
// iter_div_generic: iterative radix-2 non-restoring integer divider.
//   clk, rst       : clock, asynchronous active-high reset
//   dividend       : numerator (WIDTH)
//   divisor        : denominator (WIDTH)
//   sign_mode      : bit1 = dividend signed, bit0 = divisor signed
//   in_valid/in_ready   : operand handshake
//   quotient/remainder  : result, quotient truncated toward zero,
//                         remainder carries the dividend's sign
//   div_by_zero    : divisor was zero (quotient all ones, remainder = dividend)
//   out_valid/out_ready : result handshake
// Latency from the accepting edge to out_valid is WIDTH+2 cycles regardless
// of the data. All outputs come from registers.
module iter_div_generic
  import iter_div_generic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t state, state_next;

  // Captured request
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;
  logic [1:0]       mode;

  // Iteration state
  logic [WIDTH-1:0] q_acc;   // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH+1:0] p_rem;   // signed partial remainder, |p_rem| < 2*d_mag
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic [CW-1:0]    cnt;

  // A WIDTH-bit operand's magnitude always fits in WIDTH unsigned bits
  // (even -2^(WIDTH-1) becomes 2^(WIDTH-1)), so the negate is done at
  // WIDTH bits rather than on the WIDTH+1-bit extension.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = mode[SM_A_SIGNED] & a_raw[WIDTH-1];
  assign b_neg = mode[SM_B_SIGNED] & b_raw[WIDTH-1];

  arith_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.value(a_raw), .neg(a_neg), .result(a_mag));
  arith_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.value(b_raw), .neg(b_neg), .result(b_mag));

  // One non-restoring step: shift in the next dividend bit, then subtract
  // the divisor if the partial remainder was non-negative, add it otherwise.
  // The new quotient bit is 1 when the result is non-negative.
  logic [WIDTH+1:0] shifted, d_ext, trial;

  assign shifted = {p_rem[WIDTH:0], q_acc[WIDTH-1]};
  assign d_ext   = {2'b00, d_mag};
  assign trial   = p_rem[WIDTH+1] ? (shifted + d_ext) : (shifted - d_ext);

  // Final correction: a negative partial remainder gets the divisor added
  // back. The corrected value lies in [0, d_mag), so WIDTH bits suffice.
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_signed, r_signed;

  assign rem_mag = p_rem[WIDTH-1:0] + (p_rem[WIDTH+1] ? d_mag : {WIDTH{1'b0}});

  arith_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.value(q_acc),   .neg(q_neg), .result(q_signed));
  arith_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.value(rem_mag), .neg(r_neg), .result(r_signed));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = ST_PREP;
      ST_PREP: state_next = ST_ITER;
      ST_ITER: if (cnt == LAST_STEP) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_raw       <= '0;
      b_raw       <= '0;
      mode        <= '0;
      q_acc       <= '0;
      d_mag       <= '0;
      p_rem       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_raw <= dividend;
            b_raw <= divisor;
            mode  <= sign_mode;
          end
        end
        ST_PREP: begin
          q_acc <= a_mag;
          d_mag <= b_mag;
          p_rem <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz    <= (b_raw == '0);
          cnt   <= '0;
        end
        ST_ITER: begin
          p_rem <= trial;
          q_acc <= {q_acc[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt   <= cnt + 1'b1;
        end
        ST_FIX: begin
          // A zero divisor still runs every step; its result is simply
          // replaced here so the latency stays data independent.
          quotient    <= dz ? {WIDTH{1'b1}} : q_signed;
          remainder   <= dz ? a_raw : r_signed;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_generic.sv
module tb_iter_div_generic;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8, quo8, rem8;
  logic [1:0]  m8;
  logic        iv8, ir8, dz8, ov8, or8;
  logic [31:0] a32, b32, quo32, rem32;
  logic [1:0]  m32;
  logic        iv32, ir32, dz32, ov32, or32;

  iter_div_generic #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .dividend(a8), .divisor(b8), .sign_mode(m8),
    .in_valid(iv8), .in_ready(ir8), .quotient(quo8), .remainder(rem8),
    .div_by_zero(dz8), .out_valid(ov8), .out_ready(or8)
  );

  iter_div_generic #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .dividend(a32), .divisor(b32), .sign_mode(m32),
    .in_valid(iv32), .in_ready(ir32), .quotient(quo32), .remainder(rem32),
    .div_by_zero(dz32), .out_valid(ov32), .out_ready(or32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: extend both operands per sign_mode, divide with plain integer
  // arithmetic (truncates toward zero, remainder follows dividend), keep the
  // low w bits.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] m, output logic [63:0] q,
                                output logic [63:0] r, output logic dz);
    logic [63:0] mask;
    longint ae, be;
    mask = (64'd1 << w) - 64'd1;
    ae = (m[1] && a[w-1]) ? longint'(a | ~mask) : longint'(a & mask);
    be = (m[0] && b[w-1]) ? longint'(b | ~mask) : longint'(b & mask);
    if (be == 0) begin
      q = mask; r = a & mask; dz = 1'b1;
    end else begin
      q = 64'(ae / be) & mask; r = 64'(ae % be) & mask; dz = 1'b0;
    end
  endfunction

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];

  // Compare process: every cycle a result is presented it must equal the
  // oldest outstanding expectation; it retires when the consumer takes it.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov8) begin
        if (q8.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out8_unexpected: got out_valid=1, want no pending result");
        end else begin
          chk("mon_q8", {56'd0, quo8}, q8[0].q);
          chk("mon_r8", {56'd0, rem8}, q8[0].r);
          chk("mon_dz8", {63'd0, dz8}, {63'd0, q8[0].dz});
          if (or8) void'(q8.pop_front());
        end
      end
      if (ov32) begin
        if (q32.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out32_unexpected: got out_valid=1, want no pending result");
        end else begin
          chk("mon_q32", {32'd0, quo32}, q32[0].q);
          chk("mon_r32", {32'd0, rem32}, q32[0].r);
          chk("mon_dz32", {63'd0, dz32}, {63'd0, q32[0].dz});
          if (or32) void'(q32.pop_front());
        end
      end
    end
  end

  // All tasks enter and leave at #1 after a rising edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int n;
    exp_t e;
    n = 0;
    while (!ir8 && n < 200) begin @(posedge clk); #1; n++; end
    chk("ready8", {63'd0, ir8}, 64'd1);
    model(8, {56'd0, a}, {56'd0, b}, m, e.q, e.r, e.dz);
    q8.push_back(e);
    a8 = a; b8 = b; m8 = m; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
    n = 0;
    while (!ov8 && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency8", 64'(n), 64'd10);
    $display("op8  a=%02h b=%02h mode=%b -> q=%02h r=%02h dz=%0d lat=%0d", a, b, m, quo8, rem8, dz8, n);
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    int n;
    exp_t e;
    n = 0;
    while (!ir32 && n < 200) begin @(posedge clk); #1; n++; end
    chk("ready32", {63'd0, ir32}, 64'd1);
    model(32, {32'd0, a}, {32'd0, b}, m, e.q, e.r, e.dz);
    q32.push_back(e);
    a32 = a; b32 = b; m32 = m; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic finish32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    int n;
    n = 0;
    while (!ov32 && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency32", 64'(n), 64'd34);
    $display("op32 a=%08h b=%08h mode=%b -> q=%08h r=%08h dz=%0d lat=%0d", a, b, m, quo32, rem32, dz32, n);
  endtask

  // Hand-computed WIDTH=8 vectors: a, b, mode, quotient, remainder, div_by_zero
  logic [7:0] va[10] = '{8'd100, 8'd200, 8'h80, 8'hFF, 8'h9C, 8'h9C, 8'h07, 8'h81, 8'hFF, 8'h80};
  logic [7:0] vb[10] = '{8'hF9,  8'h00,  8'hFF, 8'hFF, 8'h07, 8'h07, 8'hFD, 8'h00, 8'h10, 8'h03};
  logic [1:0] vm[10] = '{2'b11,  2'b00,  2'b11, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00};
  logic [7:0] vq[10] = '{8'hF2,  8'hFF,  8'h80, 8'h01, 8'hF2, 8'h16, 8'h00, 8'hFF, 8'h00, 8'h2A};
  logic [7:0] vr[10] = '{8'h02,  8'hC8,  8'h00, 8'h00, 8'hFE, 8'h02, 8'h07, 8'h81, 8'hFF, 8'h02};
  logic       vz[10] = '{1'b0,   1'b1,   1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};

  initial begin
    logic [63:0] mq, mr;
    logic        mz;
    logic [31:0] ra, rb, prod;
    logic [1:0]  rm;
    int          sel, n;

    rst = 1'b1;
    a8 = '0; b8 = '0; m8 = '0; iv8 = 1'b0; or8 = 1'b1;
    a32 = '0; b32 = '0; m32 = '0; iv32 = 1'b0; or32 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_ready8", {63'd0, ir8}, 64'd1);
    chk("rst_valid8", {63'd0, ov8}, 64'd0);
    chk("rst_q8", {56'd0, quo8}, 64'd0);
    chk("rst_r8", {56'd0, rem8}, 64'd0);
    chk("rst_dz8", {63'd0, dz8}, 64'd0);
    chk("rst_ready32", {63'd0, ir32}, 64'd1);
    chk("rst_valid32", {63'd0, ov32}, 64'd0);
    chk("rst_q32", {32'd0, quo32}, 64'd0);
    @(posedge clk); #1;

    // WIDTH=8 directed vectors: pin the model, then check the DUT literally
    for (int i = 0; i < 10; i++) begin
      model(8, {56'd0, va[i]}, {56'd0, vb[i]}, vm[i], mq, mr, mz);
      chk($sformatf("pin_q_%0d", i), mq, {56'd0, vq[i]});
      chk($sformatf("pin_r_%0d", i), mr, {56'd0, vr[i]});
      chk($sformatf("pin_dz_%0d", i), {63'd0, mz}, {63'd0, vz[i]});
      issue8(va[i], vb[i], vm[i]);
      chk($sformatf("lit_q8_%0d", i), {56'd0, quo8}, {56'd0, vq[i]});
      chk($sformatf("lit_r8_%0d", i), {56'd0, rem8}, {56'd0, vr[i]});
      chk($sformatf("lit_dz8_%0d", i), {63'd0, dz8}, {63'd0, vz[i]});
    end

    // WIDTH=32 backpressure: result held, in_ready low, extra in_valid ignored
    or32 = 1'b0;
    start32(32'd1000, 32'd7, 2'b00);
    finish32(32'd1000, 32'd7, 2'b00);
    for (int i = 0; i < 5; i++) begin
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom; m32 = 2'($urandom);
      @(posedge clk); #1;
      chk("bp_ready32", {63'd0, ir32}, 64'd0);
      chk("bp_valid32", {63'd0, ov32}, 64'd1);
      chk("bp_q32", {32'd0, quo32}, 64'd142);
      chk("bp_r32", {32'd0, rem32}, 64'd6);
    end
    iv32 = 1'b0; or32 = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid32", {63'd0, ov32}, 64'd0);
    chk("hs_ready32", {63'd0, ir32}, 64'd1);
    chk("hs_q_keep32", {32'd0, quo32}, 64'd142);
    repeat (40) @(posedge clk);
    #1;
    chk("bp_no_extra32", {63'd0, ov32}, 64'd0);

    // Reset in the middle of the iterations
    start32(32'd12345, 32'd67, 2'b11);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_valid32", {63'd0, ov32}, 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready32", {63'd0, ir32}, 64'd1);
    chk("mid_rst_valid32", {63'd0, ov32}, 64'd0);
    chk("mid_rst_q32", {32'd0, quo32}, 64'd0);
    chk("mid_rst_r32", {32'd0, rem32}, 64'd0);
    q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start32(32'd7, 32'd2, 2'b00);
    finish32(32'd7, 32'd2, 2'b00);
    chk("after_rst_q32", {32'd0, quo32}, 64'd3);
    chk("after_rst_r32", {32'd0, rem32}, 64'd1);

    // Random WIDTH=32 operands and modes
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 7);
      ra  = (sel == 7) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'($urandom_range(0, 3));
        1:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      rm = 2'($urandom_range(0, 3));
      start32(ra, rb, rm);
      finish32(ra, rb, rm);
      if (rb != 32'd0) begin
        prod = quo32 * rb + rem32;
        chk("rand_identity", {32'd0, prod}, {32'd0, ra});
        if (rm[1] && rem32 != 32'd0) chk("rand_rem_sign", {63'd0, rem32[31]}, {63'd0, ra[31]});
      end
    end

    n = 0;
    while ((q8.size() != 0 || q32.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
